// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared next-PC/branch codes and fetch FSM states
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        NPC_PC4  = 2'b00,
        NPC_BR   = 2'b01,
        NPC_JAL  = 2'b10,
        NPC_JALR = 2'b11
    } npc_op_e;

    localparam logic [2:0] BR_EQ = 3'b000;
    localparam logic [2:0] BR_NE = 3'b001;
    localparam logic [2:0] BR_LT = 3'b100;
    localparam logic [2:0] BR_GE = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_EX,
        S_HALT
    } state_e;

    // Unlisted branch codes resolve as not taken.
    function automatic logic br_taken(input logic [2:0] brtype,
                                      input logic       zero,
                                      input logic       brlt);
        logic taken;
        case (brtype)
            BR_EQ:   taken = zero;
            BR_NE:   taken = ~zero;
            BR_LT:   taken = brlt;
            BR_GE:   taken = ~brlt;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/pc_fetch_npc_calc.sv
// rtl/pc_fetch_npc_calc.sv - combinational next-PC selection and alignment check
module npc_calc
    import pc_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] alu_c,
    input  logic        alu_zero,
    input  logic        alu_brlt,
    input  logic [1:0]  npc_op,
    input  logic [2:0]  brtype,
    output logic [31:0] npc,
    output logic        misalign
);

    logic [31:0] seq_pc;
    logic [31:0] rel_pc;

    assign seq_pc = pc + 32'd4;
    assign rel_pc = pc + imm;

    always_comb begin
        npc = seq_pc;
        case (npc_op_e'(npc_op))
            NPC_PC4:  npc = seq_pc;
            NPC_BR:   npc = br_taken(brtype, alu_zero, alu_brlt) ? rel_pc : seq_pc;
            NPC_JAL:  npc = rel_pc;
            NPC_JALR: npc = alu_c & ~32'd1;
            default:  npc = seq_pc;
        endcase
    end

    assign misalign = |npc[1:0];

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program counter and single-outstanding instruction fetch stage
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic [1:0]  CU_npc_op,
    input  logic [2:0]  CU_brtype,
    input  logic [31:0] imm,
    input  logic        alu_zero,
    input  logic        alu_brlt,
    input  logic [31:0] alu_c,
    input  logic        ex_valid,
    output logic        irom_req,
    output logic [31:0] irom_addr,
    input  logic        irom_ack,
    input  logic [31:0] irom_inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] pc4,
    output logic        halt
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        halt_q, halt_d;
    logic [31:0] npc;
    logic        misalign;

    npc_calc u_npc_calc (
        .pc       (pc_q),
        .imm      (imm),
        .alu_c    (alu_c),
        .alu_zero (alu_zero),
        .alu_brlt (alu_brlt),
        .npc_op   (CU_npc_op),
        .brtype   (CU_brtype),
        .npc      (npc),
        .misalign (misalign)
    );

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= 32'd0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            halt_q  <= halt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        halt_d  = halt_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (irom_ack) begin
                    inst_d  = irom_inst;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (inst_ready) state_d = S_WAIT_EX;
            end
            S_WAIT_EX: begin
                // A misaligned target still lands in the PC so it can be inspected after halting.
                if (ex_valid) begin
                    pc_d    = npc;
                    halt_d  = misalign;
                    state_d = misalign ? S_HALT : S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    assign irom_req   = (state_q == S_FETCH);
    assign inst_valid = (state_q == S_ISSUE);
    assign irom_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_pc    = pc_q;
    assign pc4        = pc_q + 32'd4;
    assign halt       = halt_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed and random checks of pc_fetch against a next-PC reference model
module tb_pc_fetch;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n = 1'b0;
    logic [1:0]  CU_npc_op = 2'd0;
    logic [2:0]  CU_brtype = 3'd0;
    logic [31:0] imm = 32'd0;
    logic        alu_zero = 1'b0;
    logic        alu_brlt = 1'b0;
    logic [31:0] alu_c = 32'd0;
    logic        ex_valid = 1'b0;
    logic        irom_req;
    logic [31:0] irom_addr;
    logic        irom_ack = 1'b0;
    logic [31:0] irom_inst = 32'd0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc4;
    logic        halt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc = 32'd0;

    always #5 cpu_clk = ~cpu_clk;

    pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst_n  (cpu_rst_n),
        .CU_npc_op  (CU_npc_op),
        .CU_brtype  (CU_brtype),
        .imm        (imm),
        .alu_zero   (alu_zero),
        .alu_brlt   (alu_brlt),
        .alu_c      (alu_c),
        .ex_valid   (ex_valid),
        .irom_req   (irom_req),
        .irom_addr  (irom_addr),
        .irom_ack   (irom_ack),
        .irom_inst  (irom_inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .pc4        (pc4),
        .halt       (halt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    // Reference: next PC straight from the ISA rules.
    function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic [1:0] op,
                                            input logic [2:0] br, input logic [31:0] off,
                                            input logic z, input logic lt, input logic [31:0] ac);
        bit taken;
        taken = (br == 3'd0 && z) || (br == 3'd1 && !z) || (br == 3'd4 && lt) || (br == 3'd5 && !lt);
        if (op == 2'd0) return pc + 32'd4;
        if (op == 2'd1) return taken ? pc + off : pc + 32'd4;
        if (op == 2'd2) return pc + off;
        return {ac[31:1], 1'b0};
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_req"}, 32'(irom_req), 32'd0);
        chk({tag, "_addr"}, irom_addr, 32'd0);
        chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_inst"}, inst, 32'd0);
        chk({tag, "_inst_pc"}, inst_pc, 32'd0);
        chk({tag, "_pc4"}, pc4, 32'd4);
        chk({tag, "_halt"}, 32'(halt), 32'd0);
    endtask

    // Entered #1 after an edge with the DUT in FETCH; leaves it in FETCH/HALT (or WAIT_EX if stop_wait).
    task automatic run_instr(input int fd, input int rd, input int ed,
                             input logic [1:0] op, input logic [2:0] br, input logic [31:0] off,
                             input logic z, input logic lt, input logic [31:0] ac, input bit stop_wait);
        logic [31:0] word;
        logic [31:0] exp;
        word = $urandom;
        chk("fetch_req", 32'(irom_req), 32'd1);
        chk("fetch_addr", irom_addr, m_pc);
        for (int i = 0; i < fd; i++) begin
            irom_ack = 1'b0; irom_inst = $urandom;
            ex_valid = 1'($urandom); inst_ready = 1'($urandom);
            tick();
            chk("fetch_wait_req", 32'(irom_req), 32'd1);
            chk("fetch_wait_addr", irom_addr, m_pc);
        end
        irom_ack = 1'b1; irom_inst = word;
        ex_valid = 1'($urandom); inst_ready = 1'($urandom);
        tick();
        chk("issue_valid", 32'(inst_valid), 32'd1);
        chk("issue_inst", inst, word);
        chk("issue_inst_pc", inst_pc, m_pc);
        chk("issue_pc4", pc4, m_pc + 32'd4);
        chk("issue_req", 32'(irom_req), 32'd0);
        for (int i = 0; i < rd; i++) begin
            inst_ready = 1'b0; irom_ack = 1'($urandom); irom_inst = $urandom;
            ex_valid = 1'($urandom);
            tick();
            chk("issue_wait_valid", 32'(inst_valid), 32'd1);
            chk("issue_wait_inst", inst, word);
        end
        inst_ready = 1'b1; irom_ack = 1'($urandom); irom_inst = $urandom; ex_valid = 1'b0;
        tick();
        inst_ready = 1'b0;
        chk("wait_valid", 32'(inst_valid), 32'd0);
        chk("wait_req", 32'(irom_req), 32'd0);
        chk("wait_inst", inst, word);
        if (stop_wait) return;
        for (int i = 0; i < ed; i++) begin
            ex_valid = 1'b0; irom_ack = 1'($urandom); irom_inst = $urandom;
            inst_ready = 1'($urandom); CU_npc_op = 2'($urandom); imm = $urandom;
            tick();
            chk("ex_wait_inst", inst, word);
            chk("ex_wait_inst_pc", inst_pc, m_pc);
            chk("ex_wait_req", 32'(irom_req), 32'd0);
        end
        ex_valid = 1'b1; irom_ack = 1'($urandom); inst_ready = 1'($urandom);
        CU_npc_op = op; CU_brtype = br; imm = off; alu_zero = z; alu_brlt = lt; alu_c = ac;
        exp = ref_npc(m_pc, op, br, off, z, lt, ac);
        tick();
        ex_valid = 1'b0; irom_ack = 1'b0; inst_ready = 1'b0;
        m_pc = exp;
        chk("npc_addr", irom_addr, exp);
        chk("npc_inst_pc", inst_pc, exp);
        if (exp[1:0] != 2'b00) begin
            chk("misalign_halt", 32'(halt), 32'd1);
            chk("misalign_req", 32'(irom_req), 32'd0);
        end else begin
            chk("next_halt", 32'(halt), 32'd0);
            chk("next_req", 32'(irom_req), 32'd1);
        end
    endtask

    initial begin
        repeat (3) @(posedge cpu_clk);
        #1;
        check_reset_values("rst");
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        #1;
        chk("idle_req", 32'(irom_req), 32'd0);
        tick();
        chk("first_req", 32'(irom_req), 32'd1);

        // Back-to-back sequential fetches, one every three cycles.
        for (int i = 0; i < 4; i++) run_instr(0, 0, 0, 2'd0, 3'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("seq_pc", irom_addr, 32'h10);

        run_instr(0, 0, 0, 2'd1, 3'd0, 32'h20, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("beq_taken", irom_addr, 32'h30);
        run_instr(0, 0, 0, 2'd2, 3'd0, -32'sd32, 1'b0, 1'b0, 32'd0, 1'b0);
        run_instr(0, 0, 0, 2'd1, 3'd0, 32'h20, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("beq_not_taken", irom_addr, 32'h14);
        run_instr(0, 0, 0, 2'd2, 3'd0, 32'h2C, 1'b0, 1'b0, 32'd0, 1'b0);
        run_instr(0, 0, 0, 2'd1, 3'd5, -32'sd8, 1'b0, 1'b1, 32'd0, 1'b0);
        chk("bge_not_taken", irom_addr, 32'h44);
        run_instr(0, 0, 0, 2'd2, 3'd0, -32'sd4, 1'b0, 1'b0, 32'd0, 1'b0);
        run_instr(0, 0, 0, 2'd1, 3'd4, -32'sd8, 1'b0, 1'b1, 32'd0, 1'b0);
        chk("blt_taken", irom_addr, 32'h38);

        run_instr(3, 2, 2, 2'd0, 3'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("slow_pc4", irom_addr, 32'h3C);

        for (int n = 0; n < 24; n++) begin
            run_instr($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                      2'($urandom), 3'($urandom), $urandom & ~32'h3,
                      1'($urandom), 1'($urandom), $urandom & ~32'h2, 1'b0);
        end

        run_instr(0, 0, 0, 2'd3, 3'd0, 32'd0, 1'b0, 1'b0, 32'h1001, 1'b0);
        chk("jalr_aligned", irom_addr, 32'h1000);
        run_instr(0, 0, 0, 2'd2, 3'd0, 32'h80 - 32'h1000, 1'b0, 1'b0, 32'd0, 1'b0);
        run_instr(0, 0, 0, 2'd0, 3'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("pre_reset_pc", inst_pc, 32'h80);

        // Asynchronous reset while waiting on execute.
        #3 cpu_rst_n = 1'b0;
        #1 check_reset_values("rst_wait_ex");
        irom_ack = 1'b1; irom_inst = 32'hDEAD_BEEF;
        tick();
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        tick();
        irom_ack = 1'b0;
        m_pc = 32'd0;
        chk("restart_inst", inst, 32'd0);
        chk("restart_req", 32'(irom_req), 32'd1);
        chk("restart_addr", irom_addr, 32'd0);

        // Reset in FETCH drops the request without waiting for a clock.
        #2 cpu_rst_n = 1'b0;
        #1 chk("rst_fetch_req", 32'(irom_req), 32'd0);
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        tick();

        run_instr(0, 0, 0, 2'd3, 3'd0, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFD, 1'b0);
        run_instr(0, 1, 0, 2'd0, 3'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("wrap_pc", irom_addr, 32'd0);

        run_instr(0, 0, 0, 2'd3, 3'd0, 32'd0, 1'b0, 1'b0, 32'h1003, 1'b0);
        chk("jalr_misalign_addr", irom_addr, 32'h1002);
        for (int i = 0; i < 4; i++) begin
            irom_ack = 1'b1; ex_valid = 1'b1; inst_ready = 1'b1;
            tick();
            chk("halt_sticky", 32'(halt), 32'd1);
            chk("halt_req", 32'(irom_req), 32'd0);
            chk("halt_addr", irom_addr, 32'h1002);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
